// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer: function codes,
// controller states, flag bit positions and the shift-op classifier.
package alu_pkg;

  // ALU function codes; bit 4 selects 32-bit mode, bits 3:0 the operation.
  localparam logic [4:0] FS_PASSA16 = 5'b00000;
  localparam logic [4:0] FS_PASSB16 = 5'b00001;
  localparam logic [4:0] FS_ADD16   = 5'b00100;
  localparam logic [4:0] FS_SUB16   = 5'b00101;
  localparam logic [4:0] FS_LSL16   = 5'b01011;
  localparam logic [4:0] FS_LSR16   = 5'b01100;
  localparam logic [4:0] FS_ASR16   = 5'b01101;
  localparam logic [4:0] FS_CSL16   = 5'b01110;
  localparam logic [4:0] FS_CSR16   = 5'b01111;
  localparam logic [4:0] FS_PASSA32 = 5'b10000;
  localparam logic [4:0] FS_ADD32   = 5'b10100;
  localparam logic [4:0] FS_SUB32   = 5'b10101;
  localparam logic [4:0] FS_LSL32   = 5'b11011;
  localparam logic [4:0] FS_LSR32   = 5'b11100;
  localparam logic [4:0] FS_ASR32   = 5'b11101;
  localparam logic [4:0] FS_CSL32   = 5'b11110;
  localparam logic [4:0] FS_CSR32   = 5'b11111;

  // Lowest operation code that is a single-bit shift or rotate.
  localparam logic [3:0] SHIFT_BASE = 4'b1011;

  // Positions of the flags inside a {Z,C,N,O} nibble.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for the shift/rotate codes that the sequencer repeats N times.
  function automatic logic is_shift(input logic [4:0] fs);
    return (fs[3:0] >= SHIFT_BASE);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Request-side controller for the combinational ALU. Accepts one operation,
// replays single-bit shifts/rotates for the requested number of passes,
// returns the final result and owns the architectural {Z,C,N,O} register.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [4:0]       ReqFunSel,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  input  logic [CNT_W-1:0] ReqCount,
  input  logic             ReqWF,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic [3:0]       RspFlags,
  output logic [4:0]       FunSel,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             WF,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [3:0]       FlagsOut,
  output logic [3:0]       Flags,
  output logic             Busy
);

  state_t           state_q,     state_d;
  logic [4:0]       op_q,        op_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [CNT_W-1:0] remain_q,    remain_d;
  logic             wf_q,        wf_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [3:0]       flags_q,     flags_d;

  logic op_is_shift;
  logic more_passes;

  assign op_is_shift = is_shift(op_q);
  assign more_passes = op_is_shift && (remain_q > CNT_W'(1));

  // Next-state, datapath updates and ALU drive; everything defaults to hold/zero.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    b_d         = b_q;
    remain_d    = remain_q;
    wf_d        = wf_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;
    ReqReady    = 1'b0;
    RspValid    = 1'b0;
    FunSel      = 5'b00000;
    A           = '0;
    B           = '0;
    WF          = 1'b0;

    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          op_d     = ReqFunSel;
          acc_d    = ReqA;
          b_d      = ReqB;
          remain_d = ReqCount;
          wf_d     = ReqWF;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        A = acc_q;
        B = b_q;
        // A zero-count shift degenerates to pass-through A in the same width mode.
        if (op_is_shift && (remain_q == '0)) begin
          FunSel = {op_q[4], 4'b0000};
        end else begin
          FunSel = op_q;
        end

        if (more_passes) begin
          acc_d    = ALUOut;
          remain_d = remain_q - CNT_W'(1);
        end else begin
          WF          = 1'b1;
          rsp_data_d  = ALUOut;
          rsp_flags_d = FlagsOut;
          if (wf_q) begin
            flags_d = FlagsOut;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        RspValid = 1'b1;
        if (RspReady) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      op_q        <= 5'b00000;
      acc_q       <= '0;
      b_q         <= '0;
      remain_q    <= '0;
      wf_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0000;
      flags_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      remain_q    <= remain_d;
      wf_q        <= wf_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end

  assign RspData  = rsp_data_q;
  assign RspFlags = rsp_flags_q;
  assign Flags    = flags_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU closes the loop,
// and each request is predicted pass by pass from the sequencing rules.
module tb_alu_sequencer;

  logic        Clock;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [4:0]  ReqFunSel;
  logic [31:0] ReqA;
  logic [31:0] ReqB;
  logic [4:0]  ReqCount;
  logic        ReqWF;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic [3:0]  RspFlags;
  logic [4:0]  FunSel;
  logic [31:0] A;
  logic [31:0] B;
  logic        WF;
  logic [31:0] ALUOut;
  logic [3:0]  FlagsOut;
  logic [3:0]  Flags;
  logic        Busy;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [3:0]  modelFlags  = 4'b0000;
  logic [31:0] lastRspData;
  logic [3:0]  lastRspFlags;
  logic [35:0] aluAll;

  alu_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqFunSel(ReqFunSel),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqCount (ReqCount),
    .ReqWF    (ReqWF),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspData  (RspData),
    .RspFlags (RspFlags),
    .FunSel   (FunSel),
    .A        (A),
    .B        (B),
    .WF       (WF),
    .ALUOut   (ALUOut),
    .FlagsOut (FlagsOut),
    .Flags    (Flags),
    .Busy     (Busy)
  );

  // Free-running clock, 10 ns period.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural ALU: returns {Z,C,N,O, result}; 16-bit mode zero-extends.
  function automatic logic [35:0] aluEval(input logic [4:0] fs, input logic [31:0] aIn,
                                          input logic [31:0] bIn);
    logic [31:0] mask, a, b, res;
    logic [32:0] wide;
    int          msb;
    logic        c, o;
    mask = fs[4] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    msb  = fs[4] ? 31 : 15;
    a = aIn & mask;
    b = bIn & mask;
    c = 1'b0;
    o = 1'b0;
    res = 32'h0;
    wide = 33'h0;
    case (fs[3:0])
      4'b0000: res = a;
      4'b0001: res = b;
      4'b0100: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[31:0] & mask;
        c    = wide[msb+1];
        o    = (a[msb] == b[msb]) && (res[msb] != a[msb]);
      end
      4'b0101: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[31:0] & mask;
        c    = (a < b);
        o    = (a[msb] != b[msb]) && (res[msb] != a[msb]);
      end
      4'b0110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      4'b1011: begin c = a[msb]; res = (a << 1) & mask; end
      4'b1100: begin c = a[0];   res = a >> 1; end
      4'b1101: begin c = a[0];   res = (a >> 1) | (a & (32'h1 << msb)); end
      4'b1110: begin c = a[msb]; res = ((a << 1) | (a >> msb)) & mask; end
      4'b1111: begin c = a[0];   res = (a >> 1) | ({31'h0, a[0]} << msb); end
      default: res = 32'h0;
    endcase
    return {(res == 32'h0), c, res[msb], o, res};
  endfunction

  // Close the loop with the ALU model; FlagsOut is garbage when WF is low.
  always_comb begin
    aluAll   = aluEval(FunSel, A, B);
    ALUOut   = aluAll[31:0];
    FlagsOut = WF ? aluAll[35:32] : ~aluAll[35:32];
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one request from an IDLE negedge and follow it to the next IDLE negedge.
  task automatic applyStimulus(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] cnt, input logic wf, input int rspDelay,
                               input logic holdValid);
    logic        shiftOp;
    int          passes;
    logic [4:0]  fsEff;
    logic [31:0] acc;
    logic [35:0] r;
    shiftOp = (fs[3:0] >= 4'b1011);
    passes  = shiftOp ? ((cnt == 5'd0) ? 1 : int'(cnt)) : 1;
    fsEff   = (shiftOp && cnt == 5'd0) ? {fs[4], 4'b0000} : fs;
    acc     = a;
    r       = 36'h0;

    ReqFunSel = fs;
    ReqA      = a;
    ReqB      = b;
    ReqCount  = cnt;
    ReqWF     = wf;
    ReqValid  = 1'b1;
    checkOutput("idle_req_ready", 32'(ReqReady), 32'd1);
    @(posedge Clock);
    #1;
    ReqValid  = holdValid;
    ReqFunSel = 5'($urandom);
    ReqA      = $urandom;
    ReqB      = $urandom;
    ReqCount  = 5'($urandom);
    ReqWF     = 1'($urandom);

    for (int p = 0; p < passes; p++) begin
      @(negedge Clock);
      checkOutput("exec_busy",      32'(Busy),     32'd1);
      checkOutput("exec_req_ready", 32'(ReqReady), 32'd0);
      checkOutput("exec_rsp_valid", 32'(RspValid), 32'd0);
      checkOutput("exec_funsel",    32'(FunSel),   32'(fsEff));
      checkOutput("exec_a",         A,             acc);
      checkOutput("exec_b",         B,             b);
      checkOutput("exec_wf",        32'(WF),       32'(p == passes - 1));
      r   = aluEval(fsEff, acc, b);
      acc = r[31:0];
    end
    if (wf) modelFlags = r[35:32];

    @(negedge Clock);
    checkOutput("resp_valid",     32'(RspValid), 32'd1);
    checkOutput("resp_data",      RspData,       acc);
    checkOutput("resp_flags",     32'(RspFlags), 32'(r[35:32]));
    checkOutput("resp_flags_reg", 32'(Flags),    32'(modelFlags));
    checkOutput("resp_alu_idle",  32'(FunSel) | A | B | 32'(WF), 32'd0);
    lastRspData  = RspData;
    lastRspFlags = RspFlags;

    for (int d = 0; d < rspDelay; d++) begin
      @(negedge Clock);
      checkOutput("hold_valid",     32'(RspValid), 32'd1);
      checkOutput("hold_data",      RspData,       acc);
      checkOutput("hold_flags",     32'(RspFlags), 32'(r[35:32]));
      checkOutput("hold_req_ready", 32'(ReqReady), 32'd0);
    end

    RspReady = 1'b1;
    @(posedge Clock);
    #1;
    RspReady = 1'b0;
    if (!holdValid) ReqValid = 1'b0;

    @(negedge Clock);
    checkOutput("back_req_ready", 32'(ReqReady), 32'd1);
    checkOutput("back_busy",      32'(Busy),     32'd0);
    checkOutput("back_rsp_valid", 32'(RspValid), 32'd0);
    checkOutput("back_flags",     32'(Flags),    32'(modelFlags));
  endtask

  // Request whose shift is cut short by reset in its fifth pass.
  task automatic resetMidShift();
    logic [31:0] acc;
    logic [35:0] r;
    logic [31:0] a;
    a = $urandom;
    acc = a;
    ReqFunSel = 5'b11110;
    ReqA      = a;
    ReqB      = $urandom;
    ReqCount  = 5'd10;
    ReqWF     = 1'b1;
    ReqValid  = 1'b1;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      @(negedge Clock);
      r   = aluEval(5'b11110, acc, ReqB);
      acc = r[31:0];
    end
    @(negedge Clock);
    checkOutput("mid_pass5_a",    A,         acc);
    checkOutput("mid_pass5_busy", 32'(Busy), 32'd1);
    Reset = 1'b0;
    #1;
    modelFlags = 4'b0000;
    checkOutput("mid_rst_busy",      32'(Busy),     32'd0);
    checkOutput("mid_rst_req_ready", 32'(ReqReady), 32'd1);
    checkOutput("mid_rst_rsp_valid", 32'(RspValid), 32'd0);
    checkOutput("mid_rst_flags",     32'(Flags),    32'd0);
    checkOutput("mid_rst_alu",       32'(FunSel) | A | 32'(WF), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checkOutput("post_rst_rsp_valid", 32'(RspValid), 32'd0);
      checkOutput("post_rst_busy",      32'(Busy),     32'd0);
    end
  endtask

  initial begin
    logic [3:0] codes [12];
    codes = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
              4'b1000, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    // Reset held with random request activity.
    Reset     = 1'b0;
    RspReady  = 1'($urandom);
    ReqValid  = 1'b1;
    ReqFunSel = 5'($urandom);
    ReqA      = $urandom;
    ReqB      = $urandom;
    ReqCount  = 5'($urandom);
    ReqWF     = 1'b1;
    repeat (3) @(negedge Clock);
    checkOutput("rst_req_ready", 32'(ReqReady), 32'd1);
    checkOutput("rst_rsp_valid", 32'(RspValid), 32'd0);
    checkOutput("rst_flags",     32'(Flags),    32'd0);
    checkOutput("rst_funsel",    32'(FunSel),   32'd0);
    checkOutput("rst_a_b",       A | B,         32'd0);
    checkOutput("rst_wf",        32'(WF),       32'd0);
    checkOutput("rst_busy",      32'(Busy),     32'd0);
    checkOutput("rst_rsp",       RspData | 32'(RspFlags), 32'd0);
    ReqValid = 1'b0;
    RspReady = 1'b0;
    Reset    = 1'b1;
    @(negedge Clock);

    // ADD32 with flag commit: 0xFFFFFFFF + 1 wraps to zero with Z and C set.
    applyStimulus(5'b10100, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1, 0, 1'b0);
    checkOutput("add_data",  lastRspData,        32'h0);
    checkOutput("add_zflag", 32'(lastRspFlags[3]), 32'd1);
    checkOutput("add_flags", 32'(Flags),         32'h0000_000C);

    // Four-pass LSL32 from 1.
    applyStimulus(5'b11011, 32'h1, 32'h0, 5'd4, 1'b0, 1, 1'b0);
    checkOutput("lsl_data", lastRspData, 32'h10);

    // Zero-count CSR16 becomes a 16-bit pass-through.
    applyStimulus(5'b01111, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 0, 1'b0);
    checkOutput("csr0_data", lastRspData, 32'h0000_5678);

    // Backpressure with ReqValid held high, no flag commit, then the next request.
    applyStimulus(5'b10101, $urandom, $urandom, 5'd0, 1'b0, 3, 1'b1);
    checkOutput("bp_flags_kept", 32'(Flags), 32'h0000_000C);
    applyStimulus(5'b10111, $urandom, $urandom, 5'd3, 1'b1, 0, 1'b0);

    // Random operations.
    for (int n = 0; n < 24; n++) begin
      applyStimulus({1'($urandom), codes[$urandom_range(0, 11)]}, $urandom, $urandom,
                    5'($urandom_range(0, 6)), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    // Make the flags register non-zero, then abandon a long rotate by reset.
    applyStimulus(5'b10100, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 0, 1'b0);
    resetMidShift();
    applyStimulus(5'b11100, $urandom, $urandom, 5'd5, 1'b1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request-side controller for the datapath ALU: accepts operation requests over a valid/ready handshake, drives the ALU's FunSel/A/B/WF inputs, and samples ALUOut/FlagsOut back. It turns the ALU's single-bit shifts and rotates into multi-bit operations by feeding the result back for N passes. It also owns the architectural Z C N O flags register. It sits between the instruction control logic and the combinational ALU.

## Interface

Parameters:
- WIDTH, 32, data width; fixed by the ALU.
- CNT_W, 5, width of the repeat-count field (0..31 passes).

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  reset, asynchronous and active-low.
- ReqValid  in  1  request valid.
- ReqReady  out  1  request accepted when ReqValid && ReqReady at a rising edge.
- ReqFunSel  in  5  ALU function code.
- ReqA  in  WIDTH  operand A.
- ReqB  in  WIDTH  operand B.
- ReqCount  in  CNT_W  pass count; used by shift/rotate ops only.
- ReqWF  in  1  commit the result flags to the Flags register.
- RspValid  out  1  result valid.
- RspReady  in  1  result consumed when RspValid && RspReady at a rising edge.
- RspData  out  WIDTH  final ALUOut.
- RspFlags  out  4  final FlagsOut {Z,C,N,O}.
- FunSel  out  5  to ALU.
- A  out  WIDTH  to ALU.
- B  out  WIDTH  to ALU.
- WF  out  1  to ALU.
- ALUOut  in  WIDTH  from ALU; combinational in the same cycle.
- FlagsOut  in  4  from ALU; valid only in cycles where WF=1.
- Flags  out  4  architectural flags register {Z,C,N,O}.
- Busy  out  1  high when the state is not IDLE.

## Operation

- Shift op: ReqFunSel[3:0] >= 4'b1011 (LSL, LSR, ASR, CSL, CSR, in both 16- and 32-bit modes).
- States and transitions:
  - IDLE:
    - ReqReady=1.
    - On accept, latch op, A (into the accumulator), B, count and WF.
    - Next state EXEC.
  - EXEC: drive FunSel=op, A=accumulator, B=latched B.
    - Shift op with remaining count > 1: WF=0, accumulator<=ALUOut, remaining-1, stay in EXEC.
    - Final pass:
      - WF=1.
      - RspData<=ALUOut, RspFlags<=FlagsOut.
      - If the latched WF is set, Flags<=FlagsOut.
      - Next state RESP.
  - RESP: RspValid=1, RspData and RspFlags held stable. On RspReady, go to IDLE.
- Number of passes:
  - Non-shift ops: exactly 1 pass; ReqCount is ignored.
  - Shift op with count N >= 1: N passes.
  - Shift op with count 0: one pass with FunSel={op[4],4'b0000} (pass-through A in the op's width mode).
- ALU outputs are zero (FunSel=0, A=0, B=0, WF=0) outside EXEC.
- Arithmetic: the accumulator is WIDTH bits. The 16-bit zero-extension is done by the ALU; the sequencer does not mask.
- ReqReady=0 in EXEC and RESP. ReqValid is ignored while busy; no queueing.
- Reset mid-operation: the operation is abandoned, no response is produced, and the state returns to IDLE.

## Timing

- Reset values: state IDLE, ReqReady=1, RspValid=0, RspData=0, RspFlags=0, Flags=0, FunSel=0, A=0, B=0, WF=0, Busy=0.
- Latency: accept at edge t, then EXEC in cycles t+1 .. t+P, then RspValid from cycle t+P+1 (P = number of passes). Non-shift ops: RspValid 2 cycles after accept.
- Minimum throughput: one op per P+2 cycles (one IDLE cycle between ops).
- Flags changes only on the final-pass edge of an op with ReqWF=1, or on reset.

## Structure

- Shared package alu_pkg:
  - FunSel constants (FS_ADD32=5'b10100, FS_LSL32=5'b11011, FS_PASSA16=5'b00000, ...).
  - The state enum {IDLE, EXEC, RESP}.
  - The is_shift() helper.
  - Flag bit indices Z=3, C=2, N=1, O=0.
- Single module; no sub-module. The ALU is instantiated alongside it, not inside it.

## Test plan

- Reset:
  - Stimulus: Reset low with random inputs.
  - Response: ReqReady=1, RspValid=0, Flags=0, FunSel=0, WF=0, Busy=0.
- ADD32 with flag commit:
  - Stimulus: FunSel=10100, A=0xFFFFFFFF, B=1, ReqWF=1.
  - Response: one EXEC cycle with WF=1, RspValid 2 cycles after accept, RspData=0, RspFlags[3]=1, Flags equal to RspFlags.
- Multi-pass shift:
  - Stimulus: LSL32 (11011), A=1, count=4.
  - Response: A bus shows 1, 2, 4, 8 over 4 EXEC cycles; WF=0 on the first three and 1 on the last; RspData=0x10, valid 5 cycles after accept.
- Count zero:
  - Stimulus: CSR16 (01111), A=0x12345678, count=0.
  - Response: a single pass with FunSel=00000, RspData=0x00005678.
- Backpressure and no-commit:
  - Stimulus: an ReqWF=0 op, with RspReady held low for 3 cycles and ReqValid high throughout.
  - Response: RspValid and RspData stable, ReqReady=0, the second request is accepted only after the IDLE return, and Flags are unchanged.
- Reset mid-shift:
  - Stimulus: Reset asserted during pass 5 of a 10-pass CSL32.
  - Response: IDLE immediately, RspValid never asserted, Flags=0, and the next request completes normally.
